alu_result_stage: RTL

- Registered output stage directly downstream of the combinational ALU. It captures Out/Oddparitty/Invalid plus the issuing opcode through a valid/ready handshake, in a 2-entry skid buffer.
- Re-checks the ALU parity flag and maintains saturating result/invalid counters for software.
- Decouples the combinational ALU from downstream backpressure without a combinational ready path.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_sat_counter.sv | 24 ++
 rtl/alu_result_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, buffer FSM states,
// per-entry side-band fields and the parity-checked opcode decode.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND     = 4'd0,
    OP_XOR     = 4'd1,
    OP_ADD     = 4'd2,
    OP_MUL     = 4'd3,
    OP_ABSDIFF = 4'd4,
    OP_DIV     = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  // Side-band fields travelling with each result word.
  typedef struct packed {
    logic            invalid;
    logic [OP_W-1:0] op;
    logic            par_err;
  } entry_meta_t;

  // Only the arithmetic ops carry a meaningful ALU parity flag.
  function automatic logic is_par_op(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_MUL, OP_ABSDIFF, OP_DIV};
  endfunction

endpackage

// File: rtl/alu_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module alu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up, stick at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the combinational ALU: a 2-entry skid buffer
// (head + skid) with parity re-check and saturating statistics counters.
// in_ready depends on registered state only, so out_ready never reaches it.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter bit DROP_INVALID = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  input  logic               in_oddpar,
  input  logic               in_invalid,
  input  logic [OP_W-1:0]    in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_invalid,
  output logic [OP_W-1:0]    out_op,
  output logic               out_par_err,
  input  logic               clr,
  output logic [CNT_W-1:0]   res_cnt,
  output logic [CNT_W-1:0]   inv_cnt,
  output logic               sticky_err
);

  localparam int DW = 2 * WIDTH;

  state_t      state_q, state_d;
  logic [DW-1:0] head_data_q, skid_data_q;
  entry_meta_t head_meta_q, skid_meta_q, in_meta;

  logic in_fire, out_fire, store, par_err;
  logic load_head_in, load_head_skid, load_skid;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // ALU parity flag must equal the XNOR-reduction of the result for checked ops.
  assign par_err = is_par_op(in_op) & (in_oddpar != ~^in_data);

  // Dropped entries still count as accepted by the handshake but never occupy storage.
  assign store = in_fire & ~(DROP_INVALID & in_invalid);

  assign in_meta = '{invalid: in_invalid, op: in_op, par_err: par_err};

  // Next-state and load-enable decode for the head/skid pair.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (store) begin
          load_head_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (store && out_fire) begin
          load_head_in = 1'b1;
        end else if (store) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          load_head_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Buffer occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Head and skid data registers; head always holds the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, so outputs read as zero after reset and no stale entry survives.
      head_data_q <= '0;
      head_meta_q <= '0;
      skid_data_q <= '0;
      skid_meta_q <= '0;
    end else begin
      if (load_head_in) begin
        head_data_q <= in_data;
        head_meta_q <= in_meta;
      end else if (load_head_skid) begin
        head_data_q <= skid_data_q;
        head_meta_q <= skid_meta_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_meta_q <= in_meta;
      end
    end
  end

  assign out_data    = head_data_q;
  assign out_invalid = head_meta_q.invalid;
  assign out_op      = head_meta_q.op;
  assign out_par_err = head_meta_q.par_err;

  // Sticky parity-error flag: set by any accepted mismatch, even a dropped one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sticky_err <= 1'b0;
    else if (clr)                sticky_err <= 1'b0;
    else if (in_fire && par_err) sticky_err <= 1'b1;
  end

  alu_sat_counter #(.CNT_W(CNT_W)) u_res_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (store),
    .clr   (clr),
    .cnt   (res_cnt)
  );

  alu_sat_counter #(.CNT_W(CNT_W)) u_inv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (in_fire & in_invalid),
    .clr   (clr),
    .cnt   (inv_cnt)
  );

endmodule
